// File: rtl/sberday_pkg.sv
// Shared types and constants for the accelerometer frame conditioner.
package sberday_pkg;

    typedef logic signed [7:0] accel_t;

    typedef enum logic [1:0] {
        NO_DATA = 2'd0,
        LIVE    = 2'd1,
        STALE   = 2'd2
    } accel_state_t;

    localparam int H_LAST_DEF = 799;
    localparam int V_LAST_DEF = 599;

    // Magnitude is taken in 9 bits so that -128 maps to +128 rather than wrapping.
    function automatic accel_t dead_zone(input accel_t v, input int dz);
        logic signed [8:0] v9;
        logic [8:0]        mag;
        v9  = {v[7], v};
        mag = v9[8] ? 9'(-v9) : 9'(v9);
        return (mag <= 9'(dz)) ? accel_t'(0) : v;
    endfunction

endpackage

// File: rtl/accel_axis_avg.sv
// One accelerometer axis: block average over 2**AVG_LOG2 samples, then dead zone.
module accel_axis_avg
    import sberday_pkg::*;
#(
    parameter int AVG_LOG2  = 3,
    parameter int DEAD_ZONE = 4
) (
    input  logic   pixel_clk,
    input  logic   rst_n,
    input  logic   sample_valid,
    input  accel_t sample,
    output accel_t avg,
    output logic   done
);

    // 2**AVG_LOG2 full-scale samples fit exactly, so no saturation is needed.
    localparam int SW = 8 + AVG_LOG2;

    logic signed [SW-1:0] sum_q, sum_d, total;
    logic [AVG_LOG2-1:0]  cnt_q, cnt_d;
    accel_t               avg_q, avg_d;
    logic                 last;

    assign last  = (cnt_q == '1);
    assign total = sum_q + {{AVG_LOG2{sample[7]}}, sample};
    assign done  = sample_valid && last;
    assign avg   = dead_zone(avg_q, DEAD_ZONE);

    // Accumulate; on the final sample publish the floored mean and restart the block.
    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        avg_d = avg_q;
        if (sample_valid) begin
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                sum_d = '0;
                avg_d = accel_t'(total >>> AVG_LOG2);
            end else begin
                sum_d = total;
            end
        end
    end

    // Accumulator, sample count and average registers; reset drops any partial block.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            cnt_q <= '0;
            avg_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
            avg_q <= avg_d;
        end
    end

endmodule

// File: rtl/accel_frame_conditioner.sv
// Averages X/Y accelerometer samples and republishes them once per video frame,
// with a liveness/staleness indication for the game block.
module accel_frame_conditioner
    import sberday_pkg::*;
#(
    parameter int AVG_LOG2     = 3,
    parameter int DEAD_ZONE    = 4,
    parameter int STALE_FRAMES = 8,
    parameter int H_LAST       = H_LAST_DEF,
    parameter int V_LAST       = V_LAST_DEF
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [7:0]  accel_raw_x,
    input  logic [7:0]  accel_raw_y,
    input  logic [10:0] h_coord,
    input  logic [9:0]  v_coord,
    output logic [7:0]  accel_x_filt,
    output logic [7:0]  accel_y_filt,
    output logic        frame_strobe,
    output logic        accel_valid,
    output logic        accel_stale
);

    accel_t x_avg, y_avg;
    logic   x_done, y_done;

    // Both axes see identical strobes, so their counters stay in lockstep;
    // the X instance's done alone drives the fresh flag.
    accel_axis_avg #(.AVG_LOG2(AVG_LOG2), .DEAD_ZONE(DEAD_ZONE)) u_avg_x (
        .pixel_clk    (pixel_clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (accel_raw_x),
        .avg          (x_avg),
        .done         (x_done)
    );

    accel_axis_avg #(.AVG_LOG2(AVG_LOG2), .DEAD_ZONE(DEAD_ZONE)) u_avg_y (
        .pixel_clk    (pixel_clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (accel_raw_y),
        .avg          (y_avg),
        .done         (y_done)
    );

    a_lockstep: assert property (@(posedge pixel_clk) disable iff (!rst_n) x_done == y_done);

    accel_state_t state_q, state_d;
    logic         fresh_q, fresh_d;
    logic         match, match_q, frame_evt;
    logic [7:0]   stale_cnt_q, stale_cnt_d;
    accel_t       x_q, x_d, y_q, y_d;
    logic         valid_q, valid_d, stale_q, stale_d, strobe_q;

    // A coordinate held at the last pixel must yield only one event.
    assign match     = (h_coord == 11'(H_LAST)) && (v_coord == 10'(V_LAST));
    assign frame_evt = match && !match_q;

    assign accel_x_filt = x_q;
    assign accel_y_filt = y_q;
    assign accel_valid  = valid_q;
    assign accel_stale  = stale_q;
    assign frame_strobe = strobe_q;

    // Next state, stale counting, fresh tracking and the per-frame output load.
    always_comb begin
        state_d     = state_q;
        fresh_d     = fresh_q;
        stale_cnt_d = stale_cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        valid_d     = valid_q;
        stale_d     = stale_q;

        // A sample in the same cycle as a frame event wins over the increment.
        if (sample_valid)
            stale_cnt_d = '0;
        else if (frame_evt && (stale_cnt_q < 8'(STALE_FRAMES)))
            stale_cnt_d = stale_cnt_q + 8'd1;

        if (frame_evt) begin
            fresh_d = 1'b0;
            unique case (state_q)
                LIVE:    if (9'(stale_cnt_q) + 9'd1 >= 9'(STALE_FRAMES)) state_d = STALE;
                default: if (fresh_q) state_d = LIVE;
            endcase
            unique case (state_d)
                LIVE: begin
                    x_d = x_avg;  y_d = y_avg;  valid_d = 1'b1;  stale_d = 1'b0;
                end
                STALE: begin
                    x_d = '0;  y_d = '0;  valid_d = 1'b0;  stale_d = 1'b1;
                end
                default: begin
                    x_d = '0;  y_d = '0;  valid_d = 1'b0;  stale_d = 1'b0;
                end
            endcase
        end

        // A block finishing on the frame edge is kept for the next frame.
        if (x_done) fresh_d = 1'b1;
    end

    // State, frame-detect delay and output registers.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= NO_DATA;
            fresh_q     <= 1'b0;
            match_q     <= 1'b0;
            stale_cnt_q <= '0;
            x_q         <= '0;
            y_q         <= '0;
            valid_q     <= 1'b0;
            stale_q     <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fresh_q     <= fresh_d;
            match_q     <= match;
            stale_cnt_q <= stale_cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            valid_q     <= valid_d;
            stale_q     <= stale_d;
            strobe_q    <= frame_evt;
        end
    end

endmodule
